polaris_dbus_bridge: RTL

//  Sits directly downstream of the PolarisCPU D master port. Converts one 64-bit-wide CPU data

---
 rtl/polaris_dbus_bridge_if.sv | 47 ++++
 rtl/polaris_dbus_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/polaris_dbus_bridge_if.sv
// Bus bundles for polaris_dbus_bridge: the CPU D-port side and the 16-bit external bus side.
// The CPU acts as master on the first and the bridge as master on the second.

interface polaris_dbus_cpu_if;
  logic        dcyc_i;
  logic        dstb_i;
  logic        dwe_i;
  logic [1:0]  dsiz_i;
  logic        dsigned_i;
  logic [63:0] dadr_i;
  logic [63:0] ddat_i;
  logic [63:0] ddat_o;
  logic        dack_o;

  modport master (
    output dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i,
    input  ddat_o, dack_o
  );

  modport slave (
    input  dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i,
    output ddat_o, dack_o
  );
endinterface

interface polaris_dbus_mem_if #(
  parameter int ADR_W = 24
);
  logic [ADR_W-1:0] madr_o;
  logic [15:0]      mdat_o;
  logic [15:0]      mdat_i;
  logic [1:0]       msel_o;
  logic             mwe_o;
  logic             mcyc_o;
  logic             mstb_o;
  logic             mack_i;

  modport master (
    output madr_o, mdat_o, msel_o, mwe_o, mcyc_o, mstb_o,
    input  mdat_i, mack_i
  );

  modport slave (
    input  madr_o, mdat_o, msel_o, mwe_o, mcyc_o, mstb_o,
    output mdat_i, mack_i
  );
endinterface

// File: rtl/polaris_dbus_bridge.sv
// Splits one 64-bit PolarisCPU data request into 1-4 little-endian 16-bit beats.
// Optional per-beat wait timeout with sticky tout_o is enabled by defining DBUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for dcyc_i & dstb_i; request fields latched on the accepting edge
// BEAT  | external cycle active, one beat per edge with mack_i (or timeout)
// ACK   | one-cycle dack_o with assembled/extended load data

module polaris_dbus_bridge #(
  parameter int ADR_W          = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,
  polaris_dbus_cpu_if.slave  cpu,
  polaris_dbus_mem_if.master mem,
  output logic               tout_o
);

  typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

  state_t           state, state_nxt;
  logic             we_q, sgn_q;
  logic [1:0]       siz_q;
  logic [ADR_W-1:0] adr_q;
  logic [63:0]      wdat_q;
  logic [63:0]      rdat_q;
  logic [1:0]       beat_q;

  logic             req;
  logic             timeout;
  logic             beat_done;
  logic             last_beat;
  logic [1:0]       last_idx;
  logic [ADR_W-1:0] base_adr;
  logic [1:0]       sel;
  logic [15:0]      rd_lane;
  logic [15:0]      wr_lane;
  logic [63:0]      ext_dat;

  wire unused_adr = &{1'b0, cpu.dadr_i[63:ADR_W]};

  assign req = cpu.dcyc_i & cpu.dstb_i;

  // Misaligned requests are force-aligned to their natural size.
  always_comb begin
    base_adr = cpu.dadr_i[ADR_W-1:0];
    case (cpu.dsiz_i)
      2'd1:    base_adr[0]   = 1'b0;
      2'd2:    base_adr[1:0] = 2'b00;
      2'd3:    base_adr[2:0] = 3'b000;
      default: base_adr      = cpu.dadr_i[ADR_W-1:0];
    endcase
  end

  always_comb begin
    case (siz_q)
      2'd2:    last_idx = 2'd1;
      2'd3:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  assign last_beat = (beat_q == last_idx);
  assign sel       = (siz_q == 2'd0) ? (adr_q[0] ? 2'b10 : 2'b01) : 2'b11;

`ifdef DBUS_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tout_q;

  assign timeout = (state == BEAT) & ~mem.mack_i & (tmo_cnt == '0);

  // Reloaded whenever no beat is pending, so every beat starts with a full budget.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tmo_cnt <= '0;
      tout_q  <= 1'b0;
    end else begin
      if (state != BEAT || beat_done) tmo_cnt <= TMO_LOAD;
      else                            tmo_cnt <= tmo_cnt - 1'b1;
      if (timeout) tout_q <= 1'b1;
    end
  end

  assign tout_o = tout_q;
`else
  wire [31:0] unused_tmo = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign tout_o  = 1'b0;
`endif

  assign beat_done = (state == BEAT) & (mem.mack_i | timeout);

  always_comb begin
    if (timeout)              rd_lane = 16'h0000;
    else if (siz_q == 2'd0)   rd_lane = {8'h00, (adr_q[0] ? mem.mdat_i[15:8] : mem.mdat_i[7:0])};
    else                      rd_lane = mem.mdat_i;
  end

  always_comb begin
    if (siz_q == 2'd0) begin
      wr_lane = {wdat_q[7:0], wdat_q[7:0]};
    end else begin
      case (beat_q)
        2'd0:    wr_lane = wdat_q[15:0];
        2'd1:    wr_lane = wdat_q[31:16];
        2'd2:    wr_lane = wdat_q[47:32];
        default: wr_lane = wdat_q[63:48];
      endcase
    end
  end

  always_comb begin
    case (siz_q)
      2'd0:    ext_dat = sgn_q ? {{56{rdat_q[7]}},  rdat_q[7:0]}  : {56'h0, rdat_q[7:0]};
      2'd1:    ext_dat = sgn_q ? {{48{rdat_q[15]}}, rdat_q[15:0]} : {48'h0, rdat_q[15:0]};
      2'd2:    ext_dat = sgn_q ? {{32{rdat_q[31]}}, rdat_q[31:0]} : {32'h0, rdat_q[31:0]};
      default: ext_dat = rdat_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cpu.dack_o  = 1'b0;
    cpu.ddat_o  = '0;
    mem.madr_o  = '0;
    mem.mdat_o  = '0;
    mem.msel_o  = '0;
    mem.mwe_o   = 1'b0;
    mem.mcyc_o  = 1'b0;
    mem.mstb_o  = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = BEAT;
      end
      BEAT: begin
        mem.mcyc_o = 1'b1;
        mem.mstb_o = 1'b1;
        mem.madr_o = adr_q;
        mem.msel_o = sel;
        mem.mwe_o  = we_q;
        if (we_q) mem.mdat_o = wr_lane;
        if (beat_done && last_beat) state_nxt = ACK;
      end
      ACK: begin
        state_nxt  = IDLE;
        cpu.dack_o = 1'b1;
        if (!we_q) cpu.ddat_o = ext_dat;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      we_q   <= 1'b0;
      sgn_q  <= 1'b0;
      siz_q  <= 2'd0;
      adr_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      beat_q <= 2'd0;
    end else if (state == IDLE && req) begin
      we_q   <= cpu.dwe_i;
      sgn_q  <= cpu.dsigned_i;
      siz_q  <= cpu.dsiz_i;
      adr_q  <= base_adr;
      wdat_q <= cpu.ddat_i;
      rdat_q <= '0;
      beat_q <= 2'd0;
    end else if (beat_done) begin
      case (beat_q)
        2'd0:    rdat_q[15:0]  <= rd_lane;
        2'd1:    rdat_q[31:16] <= rd_lane;
        2'd2:    rdat_q[47:32] <= rd_lane;
        default: rdat_q[63:48] <= rd_lane;
      endcase
      if (!last_beat) begin
        adr_q  <= adr_q + ADR_W'(2);
        beat_q <= beat_q + 2'd1;
      end
    end
  end

endmodule
